// File: rtl/motor_step_gen.sv
// motor_step_gen: per-axis STEP/DIR pulse generator with a signed position counter.
// The decoder registers (divider, moveDir, stepClockEna) are sampled one clock before
// the state machine acts on them; posReset acts on the edge where it is seen.
// Ports:
//   CLK, reset_n       clock, synchronous active-low reset
//   divider            step period in clocks (0 = no stepping)
//   moveDir            requested direction (1 = count up)
//   stepClockEna       run request
//   posReset           synchronous clear of cur_position (beats a simultaneous step)
//   step, dir          driver pins, registered
//   cur_position       two's-complement step count, registered
//   busy               high whenever the generator is not idle, registered
module motor_step_gen #(
    parameter int unsigned DIV_W     = 13,
    parameter int unsigned POS_W     = 32,
    parameter int unsigned PULSE_W   = 8,
    parameter int unsigned DIR_SETUP = 16
) (
    input  logic             CLK,
    input  logic             reset_n,
    input  logic [DIV_W-1:0] divider,
    input  logic             moveDir,
    input  logic             stepClockEna,
    input  logic             posReset,
    output logic             step,
    output logic             dir,
    output logic [POS_W-1:0] cur_position,
    output logic             busy
);

    localparam int unsigned P_MIN = 2 * PULSE_W;
    localparam int unsigned W_P   = (DIV_W > $clog2(P_MIN + 1)) ? DIV_W : $clog2(P_MIN + 1);
    localparam int unsigned CNT_W = (W_P > $clog2(DIR_SETUP + 1)) ? W_P : $clog2(DIR_SETUP + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DIRSET = 2'd1,
        S_RUN    = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   period_q, period_d;
    logic               step_q, step_d;
    logic               dir_q, dir_d;
    logic [POS_W-1:0]   pos_q, pos_d;
    logic               busy_q, busy_d;

    // sampled copies of the decoder registers
    logic [DIV_W-1:0]   div_q;
    logic               dir_req_q;
    logic               ena_q;

    logic               allowed;
    logic               reverse;
    logic               start;
    logic [CNT_W-1:0]   div_ext;
    logic [CNT_W-1:0]   eff_period;

    // state, datapath and input sample registers
    always_ff @(posedge CLK) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            period_q  <= '0;
            step_q    <= 1'b0;
            dir_q     <= 1'b0;
            pos_q     <= '0;
            busy_q    <= 1'b0;
            div_q     <= '0;
            dir_req_q <= 1'b0;
            ena_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            period_q  <= period_d;
            step_q    <= step_d;
            dir_q     <= dir_d;
            pos_q     <= pos_d;
            busy_q    <= busy_d;
            div_q     <= divider;
            dir_req_q <= moveDir;
            ena_q     <= stepClockEna;
        end
    end

    // next-state and datapath decode
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        period_d = period_q;
        step_d   = step_q;
        dir_d    = dir_q;
        pos_d    = pos_q;
        start    = 1'b0;

        allowed    = ena_q && (div_q != '0) && (dir_req_q == dir_q);
        reverse    = ena_q && (div_q != '0) && (dir_req_q != dir_q);
        div_ext    = CNT_W'(div_q);
        eff_period = (div_ext > CNT_W'(P_MIN)) ? div_ext : CNT_W'(P_MIN);

        case (state_q)
            S_IDLE: begin
                step_d = 1'b0;
                cnt_d  = '0;
                if (reverse) begin
                    dir_d   = dir_req_q;
                    state_d = S_DIRSET;
                end else if (allowed) begin
                    start = 1'b1;
                end
            end
            S_DIRSET: begin
                step_d = 1'b0;
                if (cnt_q == CNT_W'(DIR_SETUP - 1)) begin
                    cnt_d = '0;
                    if (allowed) begin
                        start = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RUN: begin
                // decisions are only taken at the period end, so a pulse always completes
                if (cnt_q == period_q - CNT_W'(1)) begin
                    step_d = 1'b0;
                    cnt_d  = '0;
                    if (allowed) begin
                        start = 1'b1;
                    end else if (reverse) begin
                        dir_d   = dir_req_q;
                        state_d = S_DIRSET;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d  = cnt_q + CNT_W'(1);
                    step_d = (cnt_q + CNT_W'(1)) < CNT_W'(PULSE_W);
                end
            end
            default: begin
                state_d = S_IDLE;
                step_d  = 1'b0;
                cnt_d   = '0;
            end
        endcase

        if (start) begin
            state_d  = S_RUN;
            step_d   = 1'b1;
            cnt_d    = '0;
            period_d = eff_period;
            pos_d    = dir_q ? (pos_q + POS_W'(1)) : (pos_q - POS_W'(1));
        end

        // clear wins over a step counted on the same edge
        if (posReset) begin
            pos_d = '0;
        end

        busy_d = (state_d != S_IDLE);
    end

    assign step         = step_q;
    assign dir          = dir_q;
    assign cur_position = pos_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_motor_step_gen.sv
// Testbench for motor_step_gen: timestamp-based reference model compared every cycle,
// directed scenarios with hand-computed expectations, then randomized stimulus.
module tb_motor_step_gen;

    localparam int PULSE_W   = 8;
    localparam int DIR_SETUP = 16;
    localparam int P_MIN     = 2 * PULSE_W;

    logic        CLK = 1'b0;
    logic        reset_n = 1'b0;
    logic [12:0] divider = '0;
    logic        moveDir = 1'b0;
    logic        stepClockEna = 1'b0;
    logic        posReset = 1'b0;
    logic        step;
    logic        dir;
    logic [31:0] cur_position;
    logic        busy;

    motor_step_gen #(
        .DIV_W(13), .POS_W(32), .PULSE_W(PULSE_W), .DIR_SETUP(DIR_SETUP)
    ) dut (
        .CLK(CLK), .reset_n(reset_n), .divider(divider), .moveDir(moveDir),
        .stepClockEna(stepClockEna), .posReset(posReset), .step(step), .dir(dir),
        .cur_position(cur_position), .busy(busy)
    );

    always #5 CLK = ~CLK;

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    // Tracks the mode plus absolute edge times of the last step start and setup end;
    // the controls it acts on are those seen one edge earlier.
    longint      cyc = 0;
    int          m_mode = 0;            // 0 idle, 1 direction setup, 2 running
    logic        m_dir = 0;
    logic [31:0] m_pos = 0;
    longint      t_rise = 0;
    longint      t_setup_end = 0;
    int          m_period = 0;
    logic        q_ena = 0, q_dir = 0;
    int          q_div = 0;
    logic        m_step = 0, m_busy = 0;

    always @(posedge CLK) begin
        bit allowed, rev, start;
        cyc++;
        if (!reset_n) begin
            m_mode = 0; m_dir = 0; m_pos = 0; q_ena = 0; q_dir = 0; q_div = 0;
            m_step = 0; m_busy = 0; t_rise = 0;
        end else begin
            allowed = q_ena && q_div != 0 && q_dir == m_dir;
            rev     = q_ena && q_div != 0 && q_dir != m_dir;
            start   = 0;
            if (m_mode == 0) begin
                if (rev) begin m_dir = q_dir; m_mode = 1; t_setup_end = cyc + DIR_SETUP; end
                else if (allowed) start = 1;
            end else if (m_mode == 1) begin
                if (cyc == t_setup_end) begin
                    if (allowed) start = 1; else m_mode = 0;
                end
            end else begin
                if (cyc == t_rise + m_period) begin
                    if (allowed) start = 1;
                    else if (rev) begin m_dir = q_dir; m_mode = 1; t_setup_end = cyc + DIR_SETUP; end
                    else m_mode = 0;
                end
            end
            if (start) begin
                m_mode = 2;
                t_rise = cyc;
                m_period = (q_div > P_MIN) ? q_div : P_MIN;
                m_pos = m_dir ? m_pos + 32'd1 : m_pos - 32'd1;
            end
            if (posReset) m_pos = 0;
            q_ena = stepClockEna; q_dir = moveDir; q_div = int'(divider);
            m_step = (m_mode == 2) && (cyc - t_rise < PULSE_W);
            m_busy = (m_mode != 0);
        end
    end

    // ---------------- compare + edge monitor ----------------
    bit     check_en = 0;
    logic   p_step = 0, p_busy = 0, p_dir = 0;
    longint rises[$];
    longint falls[$];
    longint busy_fall = 0;
    longint dir_chg = 0;

    always @(negedge CLK) begin
        if (check_en) begin
            chk("step", 32'(step), 32'(m_step));
            chk("dir", 32'(dir), 32'(m_dir));
            chk("busy", 32'(busy), 32'(m_busy));
            chk("cur_position", cur_position, m_pos);
        end
        if (step && !p_step) rises.push_back(cyc);
        if (!step && p_step) falls.push_back(cyc);
        if (!busy && p_busy) busy_fall = cyc;
        if (dir != p_dir) dir_chg = cyc;
        p_step = step; p_busy = busy; p_dir = dir;
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(negedge CLK);
        #1;
    endtask

    task automatic clear_mon();
        rises.delete();
        falls.delete();
    endtask

    task automatic wait_rises(input int n, input int budget);
        int i = 0;
        while (rises.size() < n && i < budget) begin tick(); i++; end
        chk("wait_rises", 32'(rises.size() >= n), 32'd1);
    endtask

    task automatic check_shape(input string tag, input int period, input int n);
        for (int i = 1; i < rises.size() && i < n; i++)
            chk({tag, "_gap"}, 32'(rises[i] - rises[i-1]), 32'(period));
        for (int i = 0; i < falls.size() && i < rises.size(); i++)
            chk({tag, "_width"}, 32'(falls[i] - rises[i]), 32'(PULSE_W));
    endtask

    initial begin
        longint t_en, s;
        // reset
        tick(); tick(); tick();
        reset_n = 1'b1;
        check_en = 1;
        chk("rst_step", 32'(step), 32'd0);
        chk("rst_dir", 32'(dir), 32'd0);
        chk("rst_pos", cur_position, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);

        // 10 steps up at period 100 (starts with a direction change from dir=0)
        clear_mon();
        divider = 13'd100; moveDir = 1'b1; stepClockEna = 1'b1;
        t_en = cyc;
        wait_rises(10, 3000);
        stepClockEna = 1'b0;
        repeat (200) tick();
        chk("A_first_rise", 32'(rises.size() > 0 ? rises[0] - t_en : 0), 32'(2 + DIR_SETUP));
        chk("A_rises", 32'(rises.size()), 32'd10);
        check_shape("A", 100, 10);
        chk("A_pos", cur_position, 32'd10);
        chk("A_busy_fall", 32'(rises.size() == 10 ? busy_fall - rises[9] : 0), 32'd100);

        // run-time reversal at period 50
        clear_mon();
        divider = 13'd50; moveDir = 1'b1; stepClockEna = 1'b1;
        wait_rises(3, 500);
        moveDir = 1'b0;
        wait_rises(6, 1000);
        stepClockEna = 1'b0;
        repeat (100) tick();
        chk("R_dir_at_period_end", 32'(rises.size() >= 3 ? dir_chg - rises[2] : 0), 32'd50);
        chk("R_setup", 32'(rises.size() >= 4 ? rises[3] - dir_chg : 0), 32'(DIR_SETUP));
        chk("R_dir", 32'(dir), 32'd0);
        chk("R_pos", cur_position, 32'd10);

        // divider below the clamp
        clear_mon();
        divider = 13'd5; stepClockEna = 1'b1;
        wait_rises(4, 200);
        stepClockEna = 1'b0;
        repeat (40) tick();
        check_shape("C", 16, 4);
        chk("C_pos", cur_position, 32'd6);

        // wrap below zero
        posReset = 1'b1; tick(); posReset = 1'b0;
        chk("W_clear", cur_position, 32'd0);
        clear_mon();
        divider = 13'd20; stepClockEna = 1'b1;
        wait_rises(3, 200);
        stepClockEna = 1'b0;
        repeat (40) tick();
        chk("W_pos", cur_position, 32'hFFFF_FFFD);

        // posReset on the step-start edge, then enable dropped 2 clocks into the pulse
        clear_mon();
        stepClockEna = 1'b1;
        tick();
        posReset = 1'b1;
        tick();
        posReset = 1'b0;
        chk("PR_step", 32'(step), 32'd1);
        chk("PR_pos", cur_position, 32'd0);
        tick();
        stepClockEna = 1'b0;
        repeat (40) tick();
        chk("E_rises", 32'(rises.size()), 32'd1);
        check_shape("E", 20, 1);
        chk("E_busy_fall", 32'(rises.size() > 0 ? busy_fall - rises[0] : 0), 32'd20);
        chk("E_pos", cur_position, 32'd0);

        // reset mid-pulse
        clear_mon();
        divider = 13'd100; moveDir = 1'b1; stepClockEna = 1'b1;
        wait_rises(2, 600);
        tick(); tick();
        reset_n = 1'b0;
        tick();
        chk("MR_step", 32'(step), 32'd0);
        chk("MR_dir", 32'(dir), 32'd0);
        chk("MR_pos", cur_position, 32'd0);
        chk("MR_busy", 32'(busy), 32'd0);
        stepClockEna = 1'b0;
        reset_n = 1'b1;
        tick();

        // randomized stimulus against the model
        for (int seg = 0; seg < 150; seg++) begin
            divider      = ($urandom_range(0, 4) == 0) ? 13'd0 : 13'($urandom_range(1, 60));
            moveDir      = 1'($urandom_range(0, 1));
            stepClockEna = ($urandom_range(0, 3) != 0);
            for (int c = 0; c < 20; c++) begin
                posReset = ($urandom_range(0, 29) == 0);
                reset_n  = ($urandom_range(0, 499) != 0);
                tick();
            end
        end
        posReset = 1'b0; reset_n = 1'b1; stepClockEna = 1'b0;
        repeat (100) tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
